// File: rtl/dl_detect_pkg.sv
// Shared types for the per-process deadlock detector: token FSM encoding and
// a helper that pulls one neighbour's dependency set out of the packed bus.
package dl_detect_pkg;

  // Upper bounds of the helper's fixed-width view of the packed data.
  localparam int DL_MAX_PROC = 64;
  localparam int DL_MAX_DEP  = 16;
  localparam int DL_DATA_W   = DL_MAX_PROC * DL_MAX_DEP;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_WAIT = 2'd2
  } tok_state_e;

  function automatic logic [DL_MAX_PROC-1:0] dep_slice(
    input logic [DL_DATA_W-1:0] data,
    input int                   proc_num,
    input int                   idx
  );
    return DL_MAX_PROC'(data >> (idx * proc_num));
  endfunction

endpackage

// File: rtl/dl_token_select.sv
// Lowest-index one-hot picker: selects which blocked neighbour receives the token.
module dl_token_select #(
  parameter int DEP_NUM = 2
) (
  input  logic [DEP_NUM-1:0] req,
  output logic [DEP_NUM-1:0] grant
);

  logic found;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < DEP_NUM; i++) begin
      if (req[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dl_proc_detect_unit.sv
// Per-process deadlock detector: propagates dependency sets, flags cycle membership
// and relays the report token. Optional input debounce under DL_STABLE_FILTER_EN.
module dl_proc_detect_unit
  import dl_detect_pkg::*;
#(
  parameter int PROC_NUM      = 4,
  parameter int PROC_ID       = 0,
  parameter int DEP_NUM       = 2,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                        dl_reset,
  input  logic                        dl_clock,
  input  logic [DEP_NUM-1:0]          proc_dep_vld_vec,
  input  logic [DEP_NUM-1:0]          in_dep_vld_vec,
  input  logic [DEP_NUM*PROC_NUM-1:0] in_dep_data_vec,
  input  logic [DEP_NUM-1:0]          token_in_vec,
  input  logic                        dl_detect_in,
  input  logic [PROC_NUM-1:0]         origin,
  input  logic                        token_clear,
  output logic                        out_dep_vld,
  output logic [PROC_NUM-1:0]         out_dep_data,
  output logic [DEP_NUM-1:0]          token_out_vec,
  output logic                        dl_detect_out
);

  localparam logic [PROC_NUM-1:0] SELF_MASK = PROC_NUM'(1) << PROC_ID;

  logic [DEP_NUM-1:0]  dep_vld;
  logic [PROC_NUM-1:0] slice [DEP_NUM];
  logic [DEP_NUM-1:0]  blk;
  logic [DEP_NUM-1:0]  hit;
  logic [DEP_NUM-1:0]  token_pick;
  logic [DEP_NUM-1:0]  token_d;
  logic [PROC_NUM-1:0] dep_union;
  logic                cyc_hit;
  logic                cyc_hit_q;
  logic                token_start;
  logic                in_hold;
  tok_state_e          state_q;
  tok_state_e          state_d;

`ifdef DL_STABLE_FILTER_EN
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  // A dependency counts only once it has been held for STABLE_CYCLES straight cycles.
  for (genvar i = 0; i < DEP_NUM; i++) begin : g_filter
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge dl_clock or negedge dl_reset) begin
      if (!dl_reset)                              cnt <= '0;
      else if (!proc_dep_vld_vec[i])              cnt <= '0;
      else if (cnt != CNT_W'(STABLE_CYCLES))      cnt <= cnt + CNT_W'(1);
    end

    assign dep_vld[i] = (cnt == CNT_W'(STABLE_CYCLES));
  end
`else
  assign dep_vld = proc_dep_vld_vec;
`endif

  for (genvar i = 0; i < DEP_NUM; i++) begin : g_dep
    assign slice[i] = PROC_NUM'(dep_slice(DL_DATA_W'(in_dep_data_vec), PROC_NUM, i));
    assign blk[i]   = dep_vld[i] & in_dep_vld_vec[i];
    assign hit[i]   = blk[i] & (|(slice[i] & SELF_MASK));
  end

  always_comb begin
    dep_union = '0;
    for (int i = 0; i < DEP_NUM; i++) begin
      if (blk[i]) dep_union = dep_union | slice[i];
    end
  end

  assign cyc_hit = |hit;

  // NOTE: sequential state uses non-blocking assignments with an asynchronous active-low clear.
  always_ff @(posedge dl_clock or negedge dl_reset) begin
    if (!dl_reset) begin
      out_dep_vld  <= 1'b0;
      out_dep_data <= '0;
      cyc_hit_q    <= 1'b0;
    end else begin
      out_dep_vld  <= |dep_vld;
      out_dep_data <= (|dep_vld) ? (SELF_MASK | dep_union) : '0;
      cyc_hit_q    <= cyc_hit;
    end
  end

  dl_token_select #(
    .DEP_NUM (DEP_NUM)
  ) u_token_select (
    .req   (hit),
    .grant (token_pick)
  );

  // Any token_in bit, or origin naming this process, starts a hold.
  assign token_start = dl_detect_in & ((|(origin & SELF_MASK)) | (|token_in_vec));

  always_ff @(posedge dl_clock or negedge dl_reset) begin
    if (!dl_reset) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (token_clear) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (token_start) state_d = ST_HOLD;
        ST_HOLD: state_d = dl_detect_in ? ST_WAIT : ST_IDLE;
        ST_WAIT: if (!dl_detect_in) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_hold = (state_q == ST_HOLD);
    token_d = (in_hold && state_d == ST_WAIT) ? token_pick : '0;
  end

  // Token is passed on the single HOLD->WAIT edge, so it is high for one cycle only.
  always_ff @(posedge dl_clock or negedge dl_reset) begin
    if (!dl_reset) token_out_vec <= '0;
    else           token_out_vec <= token_d;
  end

  assign dl_detect_out = dl_detect_in ? in_hold : cyc_hit_q;

endmodule

// File: tb/tb_dl_proc_detect_unit.sv
// Self-checking bench for dl_proc_detect_unit (PROC_ID=1): spec-level model checked
// every cycle, plus directed literal expectations. Covers DL_STABLE_FILTER_EN when defined.
module tb_dl_proc_detect_unit;

  localparam int PN = 4;
  localparam int PID = 1;
  localparam int DN = 2;
  localparam int SC = 8;

  localparam logic [1:0] P_IDLE = 2'd0;
  localparam logic [1:0] P_HOLDING = 2'd1;
  localparam logic [1:0] P_WAITING = 2'd2;

  logic             dl_clock = 1'b0;
  logic             dl_reset;
  logic [DN-1:0]    proc_dep_vld_vec;
  logic [DN-1:0]    in_dep_vld_vec;
  logic [DN*PN-1:0] in_dep_data_vec;
  logic [DN-1:0]    token_in_vec;
  logic             dl_detect_in;
  logic [PN-1:0]    origin;
  logic             token_clear;
  logic             out_dep_vld;
  logic [PN-1:0]    out_dep_data;
  logic [DN-1:0]    token_out_vec;
  logic             dl_detect_out;

  int n_checks = 0;
  int n_pass   = 0;

  dl_proc_detect_unit #(
    .PROC_NUM      (PN),
    .PROC_ID       (PID),
    .DEP_NUM       (DN),
    .STABLE_CYCLES (SC)
  ) dut (
    .dl_reset         (dl_reset),
    .dl_clock         (dl_clock),
    .proc_dep_vld_vec (proc_dep_vld_vec),
    .in_dep_vld_vec   (in_dep_vld_vec),
    .in_dep_data_vec  (in_dep_data_vec),
    .token_in_vec     (token_in_vec),
    .dl_detect_in     (dl_detect_in),
    .origin           (origin),
    .token_clear      (token_clear),
    .out_dep_vld      (out_dep_vld),
    .out_dep_data     (out_dep_data),
    .token_out_vec    (token_out_vec),
    .dl_detect_out    (dl_detect_out)
  );

  always #5 dl_clock = ~dl_clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic          vld;
    logic [PN-1:0] data;
    logic          cyc;
    logic [1:0]    phase;
    logic [DN-1:0] tok;
  } mstate_t;

  mstate_t       m;
  logic [DN-1:0] m_filt;

  function automatic mstate_t model_step(input mstate_t s, input logic [DN-1:0] dv);
    mstate_t       n;
    int            lowest;
    logic [PN-1:0] acc;
    logic [PN-1:0] sl;
    logic          member;
    n      = s;
    lowest = -1;
    acc    = '0;
    member = 1'b0;
    for (int i = 0; i < DN; i++) begin
      sl = in_dep_data_vec[i*PN +: PN];
      if (dv[i] && in_dep_vld_vec[i]) begin
        acc = acc | sl;
        if (sl[PID]) begin
          member = 1'b1;
          if (lowest < 0) lowest = i;
        end
      end
    end
    n.vld  = (dv != '0);
    n.data = (dv != '0) ? (acc | (PN'(1) << PID)) : '0;
    n.cyc  = member;
    n.tok  = '0;
    if (token_clear) n.phase = P_IDLE;
    else if (s.phase == P_IDLE) begin
      if (dl_detect_in && (origin[PID] || token_in_vec != '0)) n.phase = P_HOLDING;
    end else if (!dl_detect_in) n.phase = P_IDLE;
    else if (s.phase == P_HOLDING) begin
      n.phase = P_WAITING;
      if (lowest >= 0) n.tok = DN'(1) << lowest;
    end
    return n;
  endfunction

`ifdef DL_STABLE_FILTER_EN
  logic [SC-1:0] m_hist [DN];
  always @(posedge dl_clock or negedge dl_reset) begin
    for (int i = 0; i < DN; i++) begin
      if (!dl_reset) m_hist[i] <= '0;
      else           m_hist[i] <= {m_hist[i][SC-2:0], proc_dep_vld_vec[i]};
    end
  end
  always_comb for (int i = 0; i < DN; i++) m_filt[i] = &m_hist[i];
`else
  assign m_filt = proc_dep_vld_vec;
`endif

  always @(posedge dl_clock or negedge dl_reset) begin
    if (!dl_reset) m <= '0;
    else           m <= model_step(m, m_filt);
  end

  always @(negedge dl_clock) begin
    check("m_out_dep_vld",   32'(out_dep_vld),   32'(m.vld));
    check("m_out_dep_data",  32'(out_dep_data),  32'(m.data));
    check("m_token_out_vec", 32'(token_out_vec), 32'(m.tok));
    check("m_dl_detect_out", 32'(dl_detect_out),
          32'(dl_detect_in ? (m.phase == P_HOLDING) : m.cyc));
  end

  // ---------------- directed stimulus ----------------
  task automatic set_deps(input logic [DN-1:0] pdv, input logic [DN-1:0] idv,
                          input logic [PN-1:0] s1, input logic [PN-1:0] s0);
    proc_dep_vld_vec = pdv;
    in_dep_vld_vec   = idv;
    in_dep_data_vec  = {s1, s0};
  endtask

  task automatic edge_then_drive();
    @(negedge dl_clock);
  endtask

  initial begin
    int lat;
    dl_reset = 1'b0;
    set_deps(2'b00, 2'b00, 4'b0000, 4'b0000);
    token_in_vec = '0;
    dl_detect_in = 1'b0;
    origin       = '0;
    token_clear  = 1'b0;

    #12;
    check("reset_vld",  32'(out_dep_vld),   32'd0);
    check("reset_data", 32'(out_dep_data),  32'd0);
    check("reset_tok",  32'(token_out_vec), 32'd0);
    check("reset_det",  32'(dl_detect_out), 32'd0);

    @(negedge dl_clock); #1;
    dl_reset = 1'b1;
    set_deps(2'b01, 2'b01, 4'b0000, 4'b0100);
    @(negedge dl_clock);
`ifndef DL_STABLE_FILTER_EN
    check("hop_vld",  32'(out_dep_vld),   32'd1);
    check("hop_data", 32'(out_dep_data),  32'b0110);
    check("hop_det",  32'(dl_detect_out), 32'd0);
`endif
    #1 set_deps(2'b01, 2'b01, 4'b0000, 4'b0110);
    @(negedge dl_clock);
`ifndef DL_STABLE_FILTER_EN
    check("cycle_det", 32'(dl_detect_out), 32'd1);
`endif
    #1 set_deps(2'b00, 2'b01, 4'b0000, 4'b0110);
    @(negedge dl_clock);
`ifndef DL_STABLE_FILTER_EN
    check("drop_vld",  32'(out_dep_vld),   32'd0);
    check("drop_data", 32'(out_dep_data),  32'd0);
    check("drop_det",  32'(dl_detect_out), 32'd0);
`endif
    // Blocked but neighbour not blocked: only own bit; then partial union.
    #1 set_deps(2'b10, 2'b00, 4'b1000, 4'b0001);
    @(negedge dl_clock);
`ifndef DL_STABLE_FILTER_EN
    check("self_only_data", 32'(out_dep_data), 32'b0010);
`endif
    #1 set_deps(2'b11, 2'b10, 4'b1000, 4'b0001);
    @(negedge dl_clock);
`ifndef DL_STABLE_FILTER_EN
    check("partial_data", 32'(out_dep_data),  32'b1010);
    check("partial_det",  32'(dl_detect_out), 32'd0);
`endif

    // Report phase, both deps in the cycle -> token to neighbour 0.
    #1 set_deps(2'b11, 2'b11, 4'b0010, 4'b0110);
    repeat (SC + 2) @(negedge dl_clock);
    #1 dl_detect_in = 1'b1; origin = 4'b0010;
    @(negedge dl_clock);
    check("hold_det", 32'(dl_detect_out), 32'd1);
    check("hold_tok", 32'(token_out_vec), 32'd0);
    #1 origin = '0;
    @(negedge dl_clock);
    check("pass_tok", 32'(token_out_vec), 32'b01);
    check("pass_det", 32'(dl_detect_out), 32'd0);
    #1 token_in_vec = 2'b10;
    @(negedge dl_clock);
    check("wait_tok_once", 32'(token_out_vec), 32'd0);
    #1 token_in_vec = '0;
    @(negedge dl_clock);
    check("wait_ignores_token", 32'(dl_detect_out), 32'd0);
    #1 token_clear = 1'b1;
    @(negedge dl_clock);
    #1 token_clear = 1'b0;

    // Only neighbour 1 reaches back to us -> token to neighbour 1.
    set_deps(2'b11, 2'b11, 4'b0010, 4'b0100);
    @(negedge dl_clock);
    #1 origin = 4'b0010;
    @(negedge dl_clock);
    check("hold2_det", 32'(dl_detect_out), 32'd1);
    #1 origin = '0;
    @(negedge dl_clock);
    check("pass2_tok", 32'(token_out_vec), 32'b10);
    #1 token_clear = 1'b1;
    @(negedge dl_clock);
    #1 token_clear = 1'b0;

    // token_in and token_clear together: clear wins.
    token_in_vec = 2'b10; token_clear = 1'b1;
    @(negedge dl_clock);
    check("clr_prio_det", 32'(dl_detect_out), 32'd0);
    #1 token_in_vec = '0; token_clear = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge dl_clock);
      check("clr_prio_no_tok", 32'(token_out_vec), 32'd0);
    end

    // dl_detect_in falling in WAIT returns to IDLE, so a fresh token is accepted.
    #1 origin = 4'b0010;
    @(negedge dl_clock);
    #1 origin = '0;
    @(negedge dl_clock);
    #1 dl_detect_in = 1'b0;
    @(negedge dl_clock);
    #1 dl_detect_in = 1'b1; token_in_vec = 2'b01;
    @(negedge dl_clock);
    check("rearm_hold_det", 32'(dl_detect_out), 32'd1);
    #1 token_in_vec = '0;
    @(negedge dl_clock);
    check("rearm_tok", 32'(token_out_vec), 32'b10);
    #1 token_clear = 1'b1;
    @(negedge dl_clock);
    #1 token_clear = 1'b0;

    // Asynchronous reset while the token is being passed.
    origin = 4'b0010;
    @(negedge dl_clock);
    #1 origin = '0;
    @(posedge dl_clock); #1;
    check("pre_reset_tok", 32'(token_out_vec), 32'b10);
    dl_reset = 1'b0;
    #1;
    check("async_vld",  32'(out_dep_vld),   32'd0);
    check("async_data", 32'(out_dep_data),  32'd0);
    check("async_tok",  32'(token_out_vec), 32'd0);
    check("async_det",  32'(dl_detect_out), 32'd0);
    @(negedge dl_clock); #1;
    dl_reset = 1'b1;
    @(negedge dl_clock);
    check("post_reset_det", 32'(dl_detect_out), 32'd0);
    @(negedge dl_clock);
    check("post_reset_tok", 32'(token_out_vec), 32'd0);
    #1 dl_detect_in = 1'b0;

`ifdef DL_STABLE_FILTER_EN
    // Debounce: 7 high, 1 low, then high; output must rise 9 edges into the 2nd burst.
    set_deps(2'b00, 2'b00, 4'b0000, 4'b0000);
    repeat (SC + 2) @(negedge dl_clock);
    #1 proc_dep_vld_vec = 2'b01;
    repeat (7) @(negedge dl_clock);
    #1 proc_dep_vld_vec = 2'b00;
    @(negedge dl_clock);
    #1 proc_dep_vld_vec = 2'b01;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge dl_clock);
      if (out_dep_vld) begin
        lat = k;
        break;
      end
    end
    check("filter_latency", 32'(lat), 32'd9);
`endif

    repeat (2) @(negedge dl_clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dl_proc_detect_unit.md
Name: dl_proc_detect_unit

Overview:
- Per-process deadlock detector. One instance sits beside each dataflow process in the simulation testbench.
- Propagates the process's blocking dependencies to its neighbours and detects when its own process ID comes back around a dependency chain, meaning it is in a cycle.
- Drives its own bit of the central report unit's dl_in_vec.
- During reporting it acts as the token responder: it receives the token, holds it for one cycle, passes it to the next blocked neighbour, and clears it on token_clear.

Parameters:
- PROC_NUM, 4: total dataflow processes; width of the dependency vectors.
- PROC_ID, 0: index of this process; range 0..PROC_NUM-1.
- DEP_NUM, 2: number of neighbour dependencies (channels or sync links) this process can block on.
- STABLE_CYCLES, 8: debounce depth; used only when DL_STABLE_FILTER_EN is defined.

Ports:
- dl_reset  in  1  asynchronous, active-low reset.
- dl_clock  in  1  clock.
- proc_dep_vld_vec  in  DEP_NUM  bit i = this process is currently blocked on neighbour i.
- in_dep_vld_vec  in  DEP_NUM  bit i = neighbour i reports that it is itself blocked.
- in_dep_data_vec  in  DEP_NUM*PROC_NUM  slice i = neighbour i's accumulated dependency set.
- token_in_vec  in  DEP_NUM  bit i = neighbour i passes the token to this unit.
- dl_detect_in  in  1  report unit's dl_detect_out; high means report phase.
- origin  in  PROC_NUM  report unit's one-cycle cycle-start vector.
- token_clear  in  1  report unit's token clear.
- out_dep_vld  out  1  this process is blocked.
- out_dep_data  out  PROC_NUM  accumulated dependency set of this process.
- token_out_vec  out  DEP_NUM  one-hot token pass to neighbour i.
- dl_detect_out  out  1  drives dl_in_vec[PROC_ID].

Behaviour:
- Reset values: out_dep_vld=0, out_dep_data=0, token_out_vec=0, dl_detect_out=0, FSM=ST_IDLE.
- Dependency accumulation, registered with 1-cycle latency per hop:
  - out_dep_data <= (1<<PROC_ID) OR the union of slice i over every i where proc_dep_vld_vec[i] & in_dep_vld_vec[i].
  - out_dep_vld <= |proc_dep_vld_vec.
  - If proc_dep_vld_vec is all-zero, out_dep_data <= 0 on the next edge.
- Cycle-member flag: cyc_hit = |over i of (proc_dep_vld_vec[i] & in_dep_vld_vec[i] & slice_i[PROC_ID]). Combinational.
- Token FSM states: ST_IDLE, ST_HOLD, ST_WAIT.
  - ST_IDLE → ST_HOLD when dl_detect_in & (origin[PROC_ID] | (|token_in_vec)).
  - ST_HOLD lasts exactly 1 cycle, then → ST_WAIT. On the ST_HOLD→ST_WAIT edge, token_out_vec is registered one-hot at the lowest i with proc_dep_vld_vec[i] & in_dep_vld_vec[i] & slice_i[PROC_ID].
  - If no such i exists, token_out_vec stays 0 and the chain ends.
  - token_out_vec is high for exactly one cycle.
  - ST_WAIT → ST_IDLE on token_clear.
  - A token_in arriving while in ST_WAIT is ignored.
- dl_detect_out:
  - When dl_detect_in=0: registered cyc_hit.
  - When dl_detect_in=1: (state==ST_HOLD).
  - The mux selects on dl_detect_in combinationally.
- token_clear in any state forces ST_IDLE and token_out_vec=0 on the next edge. It has priority over a simultaneous token_in or origin.
- dl_detect_in falling while the FSM is in ST_HOLD or ST_WAIT forces ST_IDLE.
- A reset assertion mid-operation clears everything asynchronously; there is no pending token after reset.
- origin bits other than PROC_ID are ignored.
- Multiple token_in_vec bits in the same cycle are treated as one token.

Optional Feature:
- DL_STABLE_FILTER_EN defined:
  - Each proc_dep_vld_vec bit passes through a saturating counter of width $clog2(STABLE_CYCLES+1).
  - The filtered bit goes high only after STABLE_CYCLES consecutive high cycles.
  - The counter clears on any low cycle.
  - The filtered vector replaces proc_dep_vld_vec in every equation above, adding STABLE_CYCLES cycles of latency.
- DL_STABLE_FILTER_EN undefined: the raw vector is used and no counters are built.

Decomposition:
- Package dl_detect_pkg holds the token FSM state encoding (2-bit) and a function extracting slice i of the packed dependency data.
- Sub-module dl_token_select: combinational lowest-index one-hot picker, parameterised by DEP_NUM, producing the token target.

Test Plan:
- Reset while in ST_WAIT with token_out pending → all outputs 0 immediately; FSM returns to ST_IDLE.
- PROC_ID=1, DEP_NUM=2, proc_dep_vld_vec=2'b01, in_dep_vld_vec=2'b01, slice0=4'b0100 → one edge later out_dep_vld=1, out_dep_data=4'b0110, dl_detect_out=0.
- Same setup with slice0=4'b0110 → dl_detect_out=1 on the next edge; proc_dep_vld_vec drops to 0 → out_dep_vld, out_dep_data and dl_detect_out all return to 0 one cycle later.
- Report phase: dl_detect_in=1, origin=4'b0010, both deps in the cycle → ST_HOLD for one cycle with dl_detect_out=1, then token_out_vec=2'b01 for one cycle; token_clear → ST_IDLE.
- token_in_vec=2'b10 and token_clear in the same cycle → stays ST_IDLE; no token_out ever appears.
- With DL_STABLE_FILTER_EN and STABLE_CYCLES=8: dep bit high 7 cycles, low 1, then high 8 → out_dep_vld rises only after the second burst; 9-cycle total check.
